// File: rtl/arm_fetch.sv
// ---------------------------------------------------------------------------
// arm_fetch
// Instruction fetch stage that sits directly in front of the decoder.
// It holds the fetch PC and issues word requests to instruction memory, one
// at a time. Returned words are buffered in a small prefetch FIFO and
// presented to the decoder. A redirect flushes the FIFO, and any response
// still in flight is discarded when it arrives.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   imem_req     fetch request valid
//   imem_addr    word-aligned fetch address (the current fetch PC)
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  read data valid for the oldest accepted request
//   imem_rdata   returned instruction word
//   redirect     PC write from execute/decoder; flush and refetch
//   redirect_pc  new fetch address (low two bits ignored)
//   stall        decoder cannot consume the head word this cycle
//   instruction  FIFO head word (0 when empty)
//   instr_pc     address the head word was fetched from (0 when empty)
//   isactive     head entry valid
// ---------------------------------------------------------------------------
module arm_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        isactive
);

  localparam int ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Bit 0 marks an outstanding request, bit 1 marks that its data is to be
  // discarded, so the state doubles as the outstanding/discard flags.
  localparam logic [1:0] IDLE_ISSUE = 2'b00;
  localparam logic [1:0] WAIT       = 2'b01;
  localparam logic [1:0] DRAIN      = 2'b11;

  logic [1:0]        state_q,    state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       req_pc_q,   req_pc_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [31:0]       fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]       fifo_word_q [FIFO_DEPTH];
  logic              push;
  logic              pop;

  // Requests go out only from IDLE_ISSUE, where nothing is outstanding. In
  // that state a free FIFO slot is the whole overflow condition, so every
  // response that comes back is guaranteed room.
  assign imem_req  = !rst && !redirect && (state_q == IDLE_ISSUE) && (count_q < DEPTH_C);
  assign imem_addr = fetch_pc_q;

  assign isactive    = (count_q != '0);
  assign instruction = isactive ? fifo_word_q[rd_ptr_q] : 32'h0;
  assign instr_pc    = isactive ? fifo_pc_q[rd_ptr_q]   : 32'h0;

  assign pop = isactive && !stall && !redirect;

  // Next-state logic. A redirect overrides every push, pop and grant in the
  // same cycle. An in-flight request that has not returned yet moves to
  // DRAIN, so its data is dropped when it finally arrives.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    push       = 1'b0;
    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      if ((state_q != IDLE_ISSUE) && !imem_rvalid) begin
        state_d = DRAIN;
      end else begin
        state_d = IDLE_ISSUE;
      end
    end else begin
      case (state_q)
        IDLE_ISSUE: begin
          if (imem_req && imem_gnt) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            push    = 1'b1;
            state_d = IDLE_ISSUE;
          end
        end
        DRAIN: begin
          if (imem_rvalid) begin
            state_d = IDLE_ISSUE;
          end
        end
        default: state_d = IDLE_ISSUE;
      endcase
      if (push) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and pointer registers, with synchronous reset back to RESET_PC
  // and an empty, idle fetch stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE_ISSUE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage. It needs no reset because the outputs are masked while
  // the count is zero.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_pc_q[wr_ptr_q]   <= req_pc_q;
      fifo_word_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule
